// File: rtl/param_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : param_loader_if                                            |
// | Description : Control, byte-stream and memory port-B bundle of a loader. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface param_loader_if #(
  parameter int WORD_BYTES = 18,
  parameter int ADDR_W     = 12
);
  localparam int DATA_W = 8 * WORD_BYTES;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;

  modport master (
    output start, base_addr, word_count, in_valid, in_data,
    input  in_ready, busy, done, mem_we, mem_addr, mem_din
  );

  modport slave (
    input  start, base_addr, word_count, in_valid, in_data,
    output in_ready, busy, done, mem_we, mem_addr, mem_din
  );
endinterface
`default_nettype wire

// File: rtl/param_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : param_loader                                               |
// | Description : Packs a byte stream into words written via memory port B.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module param_loader #(
  parameter int WORD_BYTES = 18,
  parameter int ADDR_W     = 12
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  param_loader_if.slave  bus
);
  localparam int DATA_W   = 8 * WORD_BYTES;
  localparam int c_BCNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_RECV  = 2'd1;
  localparam logic [1:0] c_S_WRITE = 2'd2;
  localparam logic [1:0] c_S_DONE  = 2'd3;

  logic [1:0]          r_state;
  logic [c_BCNT_W-1:0] r_byte_cnt;
  logic [ADDR_W-1:0]   r_word_idx;
  logic [DATA_W-1:0]   r_word;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_din;

  logic [DATA_W-1:0]   w_word_next;
  logic                w_last_byte;
  logic                w_last_word;

  // Incoming byte k lands in bits [8k+7:8k]; the first byte is the LSB.
  always_comb begin
    w_word_next = r_word;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (r_byte_cnt == c_BCNT_W'(k)) begin
        w_word_next[8*k +: 8] = bus.in_data;
      end
    end
  end

  assign w_last_byte = (r_byte_cnt == c_BCNT_W'(WORD_BYTES - 1));
  assign w_last_word = ({1'b0, r_word_idx} == (r_count - (ADDR_W+1)'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_S_IDLE;
      r_byte_cnt <= '0;
      r_word_idx <= '0;
      r_word     <= '0;
      r_base     <= '0;
      r_count    <= '0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (bus.start) begin
            if (bus.word_count != '0) begin
              r_base     <= bus.base_addr;
              r_count    <= bus.word_count;
              r_byte_cnt <= '0;
              r_word_idx <= '0;
              r_state    <= c_S_RECV;
            end else begin
              r_state <= c_S_DONE;
            end
          end
        end
        c_S_RECV: begin
          // in_ready is high throughout RECV, so in_valid alone marks a transfer.
          if (bus.in_valid) begin
            r_word <= w_word_next;
            if (w_last_byte) begin
              r_byte_cnt <= '0;
              r_mem_din  <= w_word_next;
              r_mem_addr <= r_base + r_word_idx;
              r_state    <= c_S_WRITE;
            end else begin
              r_byte_cnt <= r_byte_cnt + c_BCNT_W'(1);
            end
          end
        end
        c_S_WRITE: begin
          if (w_last_word) begin
            r_state <= c_S_DONE;
          end else begin
            r_word_idx <= r_word_idx + ADDR_W'(1);
            r_state    <= c_S_RECV;
          end
        end
        default: begin
          r_state <= c_S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready = (r_state == c_S_RECV);
  assign bus.busy     = (r_state != c_S_IDLE);
  assign bus.done     = (r_state == c_S_DONE);
  assign bus.mem_we   = (r_state == c_S_WRITE);
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_din  = r_mem_din;
endmodule
`default_nettype wire

// File: tb/tb_param_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_param_loader                                            |
// | Description : Self-checking bench for param_loader with a packing model. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_param_loader;
  localparam int WB = 18;
  localparam int AW = 12;
  localparam int DW = 8 * WB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  param_loader_if #(.WORD_BYTES(WB), .ADDR_W(AW)) bus ();

  param_loader #(.WORD_BYTES(WB), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_edge = 0;

  logic [7:0]    tx_bytes[$];
  int            acc_cyc[$];
  logic [AW-1:0] wr_addr[$];
  logic [DW-1:0] wr_data[$];
  int            wr_cyc[$];
  int            done_cyc[$];
  logic          busy_after[$];
  bit            prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe registered outputs mid-cycle; cyc here equals the preceding edge count.
  always @(negedge clk) begin
    if (prev_done) busy_after.push_back(bus.busy);
    prev_done = bus.done;
    if (bus.mem_we) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_din);
      wr_cyc.push_back(cyc);
    end
    if (bus.done) done_cyc.push_back(cyc);
  end

  // Reference packing: word w is bytes w*WB .. w*WB+WB-1, first byte least significant.
  function automatic logic [DW-1:0] exp_word(input int w);
    logic [DW-1:0] r;
    r = '0;
    for (int k = WB - 1; k >= 0; k--) r = (r << 8) | DW'(tx_bytes[w*WB + k]);
    return r;
  endfunction

  function automatic logic [AW-1:0] exp_addr(input int base, input int w);
    return AW'((base + w) % (1 << AW));
  endfunction

  task automatic clear_log();
    acc_cyc.delete(); wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    done_cyc.delete(); busy_after.delete(); prev_done = 1'b0;
  endtask

  task automatic gen_bytes(input int n, input bit seq);
    tx_bytes.delete();
    for (int i = 0; i < n; i++) tx_bytes.push_back(seq ? 8'(i + 1) : 8'($urandom));
  endtask

  task automatic start_load(input int base, input int n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_addr = AW'(base);
    bus.word_count = (AW+1)'(n);
    start_edge = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.base_addr = AW'($urandom);
    bus.word_count = (AW+1)'($urandom);
  endtask

  // mode 0: continuous, 1: alternating valid, 2: random gaps
  task automatic send_bytes(input int nbytes, input int mode);
    int idx = 0;
    int budget = 0;
    int phase = 0;
    while (idx < nbytes && budget < 5000) begin
      bus.in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ((phase % 2) == 0) : (($urandom % 3) != 0);
      bus.in_data = tx_bytes[idx];
      phase++;
      if (bus.in_valid && bus.in_ready) begin
        acc_cyc.push_back(cyc + 1);
        idx++;
      end
      @(negedge clk);
      budget++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (idx != nbytes) begin
      failures++;
      $display("FAIL send_timeout accepted=%0d required=%0d", idx, nbytes);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cyc.size() == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cyc.size() == 0) begin
      failures++;
      $display("FAIL done_timeout got=none required=pulse within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.busy, bus.done, bus.mem_we} !== 4'b0 || bus.mem_addr !== '0 || bus.mem_din !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=rdy%b busy%b done%b we%b addr%0h din%0h required=all zero",
               bus.in_ready, bus.busy, bus.done, bus.mem_we, bus.mem_addr, bus.mem_din);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single(input int mode, input string tag);
    clear_log();
    gen_bytes(WB, 1'b1);
    start_load(16, 1);
    send_bytes(WB, mode);
    wait_done(100);
    checks++;
    if (wr_addr.size() != 1) begin
      failures++;
      $display("FAIL %s_write_count got=%0d required=1", tag, wr_addr.size());
    end else begin
      checks++;
      if (wr_addr[0] !== 12'd16) begin
        failures++; $display("FAIL %s_addr got=%0d required=16", tag, wr_addr[0]);
      end
      checks++;
      if (wr_data[0] !== exp_word(0)) begin
        failures++; $display("FAIL %s_data got=%h required=%h", tag, wr_data[0], exp_word(0));
      end
      checks++;
      if (acc_cyc.size() != WB || wr_cyc[0] != acc_cyc[WB-1]) begin
        failures++; $display("FAIL %s_write_latency got=%0d required=%0d", tag, wr_cyc[0], acc_cyc[acc_cyc.size()-1]);
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != wr_cyc[0] + 1) begin
        failures++; $display("FAIL %s_done got=count%0d required=one pulse at %0d", tag, done_cyc.size(), wr_cyc[0] + 1);
      end
      checks++;
      if (busy_after.size() < 1 || busy_after[0] !== 1'b0) begin
        failures++; $display("FAIL %s_busy_after_done got=%0d required=0", tag, busy_after.size() ? busy_after[0] : 1'bx);
      end
    end
  endtask

  task automatic test_zero_count();
    int rdy = 0;
    clear_log();
    start_load(50, 0);
    repeat (4) begin
      if (bus.in_ready) rdy++;
      @(negedge clk);
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != start_edge) begin
      failures++; $display("FAIL zero_done got=count%0d required=one pulse at %0d", done_cyc.size(), start_edge);
    end
    checks++;
    if (wr_addr.size() != 0 || rdy != 0) begin
      failures++; $display("FAIL zero_activity got=writes%0d ready%0d required=0 0", wr_addr.size(), rdy);
    end
  endtask

  task automatic test_wrap();
    clear_log();
    gen_bytes(2*WB, 1'b0);
    start_load(4095, 2);
    send_bytes(2*WB, 0);
    wait_done(200);
    checks++;
    if (wr_addr.size() != 2) begin
      failures++; $display("FAIL wrap_write_count got=%0d required=2", wr_addr.size());
    end else begin
      checks++;
      if (wr_addr[0] !== 12'd4095 || wr_addr[1] !== 12'd0) begin
        failures++; $display("FAIL wrap_addr got=%0d,%0d required=4095,0", wr_addr[0], wr_addr[1]);
      end
      checks++;
      if (wr_data[0] !== exp_word(0) || wr_data[1] !== exp_word(1)) begin
        failures++; $display("FAIL wrap_data got=%h required=%h", wr_data[1], exp_word(1));
      end
      checks++;
      if (wr_cyc[1] - wr_cyc[0] != WB + 1) begin
        failures++; $display("FAIL wrap_spacing got=%0d required=%0d", wr_cyc[1] - wr_cyc[0], WB + 1);
      end
      checks++;
      if (done_cyc.size() != 1) begin
        failures++; $display("FAIL wrap_done_count got=%0d required=1", done_cyc.size());
      end
    end
  endtask

  task automatic test_start_ignored();
    clear_log();
    gen_bytes(2*WB, 1'b0);
    start_load(100, 2);
    fork
      send_bytes(2*WB, 0);
      begin
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.base_addr = 12'd7; bus.word_count = 13'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (13) @(negedge clk);
        bus.start = 1'b1; bus.base_addr = 12'd900; bus.word_count = 13'd0;
        @(negedge clk);
        bus.start = 1'b0;
      end
    join
    wait_done(200);
    checks++;
    if (wr_addr.size() != 2 || done_cyc.size() != 1) begin
      failures++; $display("FAIL ignore_counts got=writes%0d dones%0d required=2 1", wr_addr.size(), done_cyc.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (wr_addr[i] !== exp_addr(100, i) || wr_data[i] !== exp_word(i)) begin
          failures++; $display("FAIL ignore_word%0d got=%0d:%h required=%0d:%h", i, wr_addr[i], wr_data[i], exp_addr(100, i), exp_word(i));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      int base = $urandom_range(0, (1 << AW) - 1);
      int n = $urandom_range(1, 3);
      int mode = $urandom_range(0, 2);
      clear_log();
      gen_bytes(n*WB, 1'b0);
      start_load(base, n);
      send_bytes(n*WB, mode);
      wait_done(1000);
      checks++;
      if (wr_addr.size() != n || done_cyc.size() != 1) begin
        failures++; $display("FAIL rand%0d_counts got=writes%0d dones%0d required=%0d 1", it, wr_addr.size(), done_cyc.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          checks++;
          if (wr_addr[i] !== exp_addr(base, i) || wr_data[i] !== exp_word(i) || wr_cyc[i] != acc_cyc[i*WB + WB - 1]) begin
            failures++; $display("FAIL rand%0d_word%0d got=%0d:%h@%0d required=%0d:%h@%0d", it, i,
                                 wr_addr[i], wr_data[i], wr_cyc[i], exp_addr(base, i), exp_word(i), acc_cyc[i*WB + WB - 1]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midload();
    clear_log();
    gen_bytes(2*WB, 1'b0);
    start_load(200, 2);
    send_bytes(10, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.busy, bus.done, bus.mem_we} !== 4'b0 || bus.mem_addr !== '0 || bus.mem_din !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got=rdy%b busy%b done%b we%b addr%0h din%0h required=all zero",
               bus.in_ready, bus.busy, bus.done, bus.mem_we, bus.mem_addr, bus.mem_din);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (wr_addr.size() != 0 || done_cyc.size() != 0) begin
      failures++; $display("FAIL midreset_activity got=writes%0d dones%0d required=0 0", wr_addr.size(), done_cyc.size());
    end
    clear_log();
    gen_bytes(WB, 1'b0);
    start_load(300, 1);
    send_bytes(WB, 2);
    wait_done(200);
    checks++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 12'd300 || wr_data[0] !== exp_word(0)) begin
      failures++; $display("FAIL after_reset_load got=writes%0d word=%h required=1 %h", wr_addr.size(),
                           wr_data.size() ? wr_data[0] : '0, exp_word(0));
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.word_count = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    test_reset();
    test_single(0, "single");
    test_single(1, "gapped");
    test_zero_count();
    test_wrap();
    test_random();
    test_start_ignored();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=completion");
    $fatal(1);
  end
endmodule
`default_nettype wire

// File: doc/param_loader.md
Name: param_loader

Overview:
- Write-side loader for the parameter memories.
- Receives a byte stream (from the host/UART front end) over a valid/ready handshake and packs each group of WORD_BYTES bytes into one parameter word.
- Each packed word is written through the otherwise-unused port B of a weight/bias memory, at consecutive addresses starting from a programmed base.
- One loader instance per memory. The inference datapath reads port A only while the loader is idle.

Parameters:
- WORD_BYTES, 18, bytes per memory word (18 for 9x16-bit conv weights, 16 for 8x16-bit dense weights, 2 for biases).
- ADDR_W, 12, memory address width.
- DATA_W, 8*WORD_BYTES, memory word width (derived; not overridden).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle load request; sampled only in IDLE.
- base_addr  in  ADDR_W  first write address; latched on accepted start.
- word_count  in  ADDR_W+1  number of words to load; latched on accepted start (0..2^ADDR_W).
- in_valid  in  1  byte available.
- in_data  in  8  byte payload.
- in_ready  out  1  loader accepts the byte this cycle.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at the end of a load.
- mem_we  out  1  port-B write enable; also drives enb.
- mem_addr  out  ADDR_W  port-B address.
- mem_din  out  DATA_W  port-B write data.

Behaviour:
- States: IDLE, RECV, WRITE, DONE (registered). All outputs decode from state or registers; there are no combinational paths from inputs to outputs.
- Reset (async, rst_n=0):
  - state is IDLE.
  - Byte counter, word counter, word register, latched base and latched count all clear to 0.
  - Outputs: in_ready=0, busy=0, done=0, mem_we=0, mem_addr=0, mem_din=0.
  - Reset mid-load aborts with no further write. A partially assembled word is discarded.
- IDLE:
  - start=1 with word_count!=0: latch base_addr and word_count, clear counters, go to RECV.
  - start=1 with word_count==0: go to DONE; no write.
  - start outside IDLE is ignored.
- RECV:
  - in_ready=1.
  - A byte transfers on in_valid&&in_ready.
  - Byte k (k=0 first) is stored at word bits [8k+7:8k], so the first byte lands in the LSBs.
  - The byte counter increments per transfer. A transfer with counter==WORD_BYTES-1 goes to WRITE and resets the counter to 0.
  - Idle cycles (in_valid=0) hold all state.
- WRITE:
  - Lasts exactly 1 cycle. mem_we=1, mem_addr=(base+word_idx) mod 2^ADDR_W, mem_din=assembled word. in_ready=0.
  - Next state: if word_idx==count-1, go to DONE; otherwise increment word_idx and go to RECV.
- DONE: done=1 for exactly 1 cycle, then IDLE. busy=1 in DONE.
- mem_addr and mem_din hold their last values outside WRITE. They are only meaningful while mem_we=1.
- Address arithmetic: ADDR_W-bit add with wrap, no error.
- Throughput: WORD_BYTES+1 cycles per word with continuous in_valid.
- Latency:
  - Start accepted at cycle t gives in_ready high at t+1.
  - The first write occurs 1 cycle after the WORD_BYTES-th accepted byte.
  - done is asserted the cycle after the final write.

Test Plan:
- WORD_BYTES=18, base=16, count=1, bytes 0x01..0x12 continuous -> exactly one mem_we pulse, mem_addr=16, mem_din=0x121110...0201, done 1 cycle later, busy low the cycle after.
- Same load with in_valid toggling 1,0,1,0 -> identical write data/address, write issued 1 cycle after the 18th accepted byte, no byte dropped or duplicated.
- count=0 -> done pulses the cycle after start, mem_we never asserts, in_ready stays 0.
- base=4095, count=2, continuous bytes -> writes at 4095 then 0, spaced 19 cycles apart, single done.
- start re-asserted while busy with different base/count -> ignored; the original load completes unchanged.
- rst_n low after 10 bytes of word 0 -> outputs zero immediately, no write. A new load after reset starts with a fresh byte 0 at the LSBs.
